fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters.
REQ-002 Parameter DW, default 8: data width, matching the FIFO write port.
REQ-003 Parameter MAX_BURST, default 8: maximum words per grant.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with these ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester write request; held while data is pending.
- last  in  N_REQ  per-requester end-of-burst marker for the current word.
- din  in  N_REQ*DW  packed requester data; slice i belongs to requester i.
- gnt  out  N_REQ  registered one-hot grant.
- fifo_full  in  1  FIFO full flag.
- fifo_wr  out  1  FIFO write strobe.
- fifo_din  out  DW  FIFO write data.
- busy  out  1  high while in state BURST.
- abort_cnt  out  8  saturating count of abandoned bursts.

Function
REQ-010 States SHALL be IDLE and BURST only.
REQ-011 In IDLE with any req high, the block SHALL select a winner round-robin starting at pointer rr_ptr, register gnt to one-hot(winner), and enter BURST next cycle.
REQ-012 In IDLE with no req high, gnt SHALL stay 0 and the state SHALL remain IDLE.
REQ-013 A transfer occurs in a cycle where gnt[i] && req[i] && !fifo_full.
REQ-014 fifo_wr SHALL equal the transfer condition combinationally.
REQ-015 fifo_din SHALL equal din slice i when gnt[i] is set, else 0.
REQ-016 First-word latency: req rising at edge t in IDLE gives gnt at t+1, and the first write may occur in cycle t+1.
REQ-017 A burst counter (width clog2(MAX_BURST)+1) SHALL clear on grant and increment on each transfer.
REQ-018 Release: on a transfer with last[i]=1, or with burst count reaching MAX_BURST, gnt SHALL clear at the next edge, the state SHALL return to IDLE, and rr_ptr SHALL become (i+1) mod N_REQ.
REQ-019 fifo_full high SHALL stall the burst: no write, no count change, no release, and gnt held, including when last is also high.
REQ-020 If the granted req drops in BURST with no transfer that cycle, the grant SHALL be released as in REQ-018 and abort_cnt SHALL increment, saturating at 255.
REQ-021 Between consecutive bursts there SHALL be exactly one IDLE (dead) cycle.
REQ-022 Non-granted requesters SHALL never cause fifo_wr, and their req/last values are don't-care.
REQ-023 gnt SHALL always be one-hot or zero.
REQ-024 rr_ptr wrap: pointer N_REQ-1 plus 1 SHALL give 0.

Reset
REQ-030 rst high SHALL immediately set state=IDLE, gnt=0, rr_ptr=0, burst count=0, abort_cnt=0, busy=0.
REQ-031 Because fifo_wr and fifo_din are derived from gnt, they SHALL read 0 during reset.
REQ-032 Reset asserted mid-burst SHALL drop gnt and fifo_wr in the same cycle, without waiting for a clock edge.
REQ-033 After rst deasserts, arbitration SHALL start from requester 0.

Structure
REQ-040 The shared package fifo_arb_pkg SHALL hold the state enum (IDLE, BURST) and default constants for N_REQ, DW and MAX_BURST.
REQ-041 Sub-module rr_pick (combinational round-robin picker; inputs req vector and rr_ptr; outputs one-hot winner and valid) SHALL be instantiated once.
REQ-042 The FIFO itself SHALL sit outside this block.

Verification
REQ-050 req=4'b0001, last on the 3rd word, fifo_full=0 -> gnt=0001 one cycle after req; 3 consecutive fifo_wr; gnt=0 after the 3rd write; rr_ptr=1.
REQ-051 req=4'b1111 continuously, last on every word -> grant order 0,1,2,3,0 with one dead cycle between grants.
REQ-052 req[2] held, last never asserted, MAX_BURST=8 -> exactly 8 writes, then forced release; abort_cnt unchanged.
REQ-053 Mid-burst fifo_full=1 for 3 cycles, with last high during the stall -> no fifo_wr and gnt held during the stall; the last word is written on the first non-full cycle, then release.
REQ-054 Granted req drops after 2 words -> gnt clears next edge; abort_cnt=1; the next requester in round-robin order is granted.
REQ-055 rst pulsed asynchronously mid-burst -> gnt=0 and fifo_wr=0 immediately; after release, requester 0 wins an all-request arbitration.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int N_REQ_DEF     = 4;
  localparam int DW_DEF        = 8;
  localparam int MAX_BURST_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Pointer width that stays legal for a single requester.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = N_REQ_DEF,
  parameter int PW = ptr_w(N_REQ_DEF)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          valid
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   lsb;
  logic [2*N-1:0] back;

  // Rotate so ptr sits at bit 0, isolate lowest set bit, rotate back.
  assign dbl    = {req, req} >> ptr;
  assign rot    = dbl[N-1:0];
  assign lsb    = rot & (~rot + {{(N-1){1'b0}}, 1'b1});
  assign back   = {lsb, lsb} << ptr;
  assign winner = back[2*N-1:N];
  assign valid  = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ requesters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    last,
  input  logic [N_REQ*DW-1:0] din,
  output logic [N_REQ-1:0]    gnt,
  input  logic                fifo_full,
  output logic                fifo_wr,
  output logic [DW-1:0]       fifo_din,
  output logic                busy,
  output logic [7:0]          abort_cnt
);

  localparam int PW = ptr_w(N_REQ);
  localparam int CW = $clog2(MAX_BURST) + 1;

  state_t           state_reg;
  logic [N_REQ-1:0] gnt_reg;
  logic [PW-1:0]    rr_ptr_reg;
  logic [CW-1:0]    burst_cnt_reg;
  logic [7:0]       abort_reg;

  logic [N_REQ-1:0] pick_win;
  logic             pick_valid;

  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (rr_ptr_reg),
    .winner (pick_win),
    .valid  (pick_valid)
  );

  // Because gnt is one-hot, OR-chains give the granted data, index and flags.
  logic [DW-1:0] din_acc [N_REQ+1];
  logic [PW-1:0] idx_acc [N_REQ+1];
  assign din_acc[0] = '0;
  assign idx_acc[0] = '0;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_sel
    assign din_acc[gi+1] = din_acc[gi] | ({DW{gnt_reg[gi]}} & din[gi*DW +: DW]);
    assign idx_acc[gi+1] = idx_acc[gi] | (gnt_reg[gi] ? PW'(gi) : '0);
  end

  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] ptr_next;
  logic          req_g;
  logic          last_g;
  logic          xfer;
  logic [CW-1:0] cnt_inc;

  assign gnt_idx  = idx_acc[N_REQ];
  assign ptr_next = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);
  assign req_g    = |(gnt_reg & req);
  assign last_g   = |(gnt_reg & last);
  assign xfer     = req_g && !fifo_full;
  assign cnt_inc  = burst_cnt_reg + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      gnt_reg       <= '0;
      rr_ptr_reg    <= '0;
      burst_cnt_reg <= '0;
      abort_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            gnt_reg       <= pick_win;
            burst_cnt_reg <= '0;
            state_reg     <= BURST;
          end
        end
        BURST: begin
          if (xfer) begin
            burst_cnt_reg <= cnt_inc;
            if (last_g || cnt_inc == CW'(MAX_BURST)) begin
              gnt_reg    <= '0;
              rr_ptr_reg <= ptr_next;
              state_reg  <= IDLE;
            end
          end else if (!req_g) begin
            // Requester walked away mid-burst: release and record it.
            gnt_reg    <= '0;
            rr_ptr_reg <= ptr_next;
            state_reg  <= IDLE;
            if (abort_reg != 8'hff) abort_reg <= abort_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign fifo_wr   = xfer;
  assign fifo_din  = din_acc[N_REQ];
  assign busy      = (state_reg == BURST);
  assign abort_cnt = abort_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed table, corner sequences, random run vs. model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    last = '0;
  logic [N*DW-1:0] din = '0;
  logic            fifo_full = 1'b0;
  logic [N-1:0]    gnt;
  logic            fifo_wr;
  logic [DW-1:0]   fifo_din;
  logic            busy;
  logic [7:0]      abort_cnt;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .din       (din),
    .gnt       (gnt),
    .fifo_full (fifo_full),
    .fifo_wr   (fifo_wr),
    .fifo_din  (fifo_din),
    .busy      (busy),
    .abort_cnt (abort_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the port, words moved, where the search starts, abort tally.
  int m_owner;
  int m_cnt;
  int m_ptr;
  int m_abort;

  logic         obs_wr;
  logic [N-1:0] obs_gnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_ptr   = 0;
    m_abort = 0;
  endtask

  task automatic model_release();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
  endtask

  task automatic model_step();
    bit found;
    found = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (!found && req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_cnt   = 0;
          found   = 1;
        end
      end
    end else if (req[m_owner] && !fifo_full) begin
      m_cnt++;
      if (last[m_owner] || m_cnt == MB) model_release();
    end else if (!req[m_owner]) begin
      model_release();
      if (m_abort < 255) m_abort++;
    end
  endtask

  task automatic drive_check(input logic [N-1:0] r, input logic [N-1:0] l,
                             input logic f, input logic [N*DW-1:0] d);
    logic [N-1:0]  e_gnt;
    logic          e_wr;
    logic [DW-1:0] e_din;
    @(negedge clk);
    req = r; last = l; fifo_full = f; din = d;
    #1;
    e_gnt = '0;
    e_wr  = 1'b0;
    e_din = '0;
    if (m_owner >= 0) begin
      e_gnt[m_owner] = 1'b1;
      e_wr  = req[m_owner] && !fifo_full;
      e_din = din[m_owner*DW +: DW];
    end
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("fifo_wr", 32'(fifo_wr), 32'(e_wr));
    chk("fifo_din", 32'(fifo_din), 32'(e_din));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("abort_cnt", 32'(abort_cnt), 32'(m_abort));
    obs_wr  = fifo_wr;
    obs_gnt = gnt;
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l,
                       input logic f, input logic [N*DW-1:0] d);
    drive_check(r, l, f, d);
    advance();
  endtask

  task automatic do_reset();
    req = '0; last = '0; fifo_full = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0]    req;
    logic [N-1:0]    last;
    logic            full;
    logic [N*DW-1:0] din;
    logic [N-1:0]    gnt;
    logic            wr;
    logic [DW-1:0]   fdin;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int wr_cnt;
    int ab0;
    logic [N-1:0] e;
    logic [N-1:0] rq;

    // Three-word burst from requester 0, then a burst stalled by fifo_full with last held.
    tbl[0]  = '{4'b0001, 4'b0000, 1'b0, 32'h5555_55A0, 4'b0000, 1'b0, 8'h00};
    tbl[1]  = '{4'b0001, 4'b0000, 1'b0, 32'h5555_55A1, 4'b0001, 1'b1, 8'hA1};
    tbl[2]  = '{4'b0001, 4'b0000, 1'b0, 32'h5555_55A2, 4'b0001, 1'b1, 8'hA2};
    tbl[3]  = '{4'b0001, 4'b0001, 1'b0, 32'h5555_55A3, 4'b0001, 1'b1, 8'hA3};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 32'h5555_55B0, 4'b0000, 1'b0, 8'h00};
    tbl[5]  = '{4'b0001, 4'b0000, 1'b0, 32'h5555_55B1, 4'b0000, 1'b0, 8'h00};
    tbl[6]  = '{4'b0001, 4'b0000, 1'b0, 32'h5555_55B2, 4'b0001, 1'b1, 8'hB2};
    tbl[7]  = '{4'b0001, 4'b0001, 1'b1, 32'h5555_55B3, 4'b0001, 1'b0, 8'hB3};
    tbl[8]  = '{4'b0001, 4'b0001, 1'b1, 32'h5555_55B3, 4'b0001, 1'b0, 8'hB3};
    tbl[9]  = '{4'b0001, 4'b0001, 1'b1, 32'h5555_55B3, 4'b0001, 1'b0, 8'hB3};
    tbl[10] = '{4'b0001, 4'b0001, 1'b0, 32'h5555_55B3, 4'b0001, 1'b1, 8'hB3};
    tbl[11] = '{4'b0000, 4'b0000, 1'b0, 32'h5555_55C0, 4'b0000, 1'b0, 8'h00};

    model_reset();
    #1 rst = 1'b1;
    #2;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_wr", 32'(fifo_wr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_abort", 32'(abort_cnt), 32'd0);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      drive_check(tbl[i].req, tbl[i].last, tbl[i].full, tbl[i].din);
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_wr", i), 32'(fifo_wr), 32'(tbl[i].wr));
      chk($sformatf("tbl%0d_din", i), 32'(fifo_din), 32'(tbl[i].fdin));
      $display("tbl row %0d: req=%b last=%b full=%b gnt=%b wr=%b din=%h",
               i, req, last, fifo_full, gnt, fifo_wr, fifo_din);
      advance();
    end

    // All requesting, last on every word: grants 0,1,2,3,0 separated by a dead cycle.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive_check(4'b1111, 4'b1111, 1'b0, $urandom);
      e = '0;
      if (k % 2 == 1) e[(k / 2) % N] = 1'b1;
      chk($sformatf("rr_order_c%0d", k), 32'(obs_gnt), 32'(e));
      advance();
    end
    cycle(4'b0000, 4'b0000, 1'b0, $urandom);
    $display("seq rr_order: 10 cycles done");

    // Requester 2 never marks last: MAX_BURST words, then a forced release.
    ab0 = m_abort;
    wr_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      cycle(4'b0100, 4'b0000, 1'b0, $urandom);
      if (obs_wr) wr_cnt++;
    end
    drive_check(4'b0000, 4'b0000, 1'b0, $urandom);
    chk("maxburst_writes", 32'(wr_cnt), 32'(MB));
    chk("maxburst_released", 32'(gnt), 32'd0);
    chk("maxburst_abort", 32'(abort_cnt), 32'(ab0));
    advance();
    $display("seq max_burst: writes=%0d", wr_cnt);

    // Requester 0 abandons after two words; requester 1 is next.
    cycle(4'b0011, 4'b0000, 1'b0, $urandom);
    cycle(4'b0011, 4'b0000, 1'b0, $urandom);
    cycle(4'b0011, 4'b0000, 1'b0, $urandom);
    drive_check(4'b0010, 4'b0000, 1'b0, $urandom);
    chk("abort_nowrite", 32'(fifo_wr), 32'd0);
    advance();
    drive_check(4'b0010, 4'b0000, 1'b0, $urandom);
    chk("abort_released", 32'(gnt), 32'd0);
    chk("abort_count", 32'(abort_cnt), 32'(ab0 + 1));
    advance();
    drive_check(4'b0010, 4'b0010, 1'b0, $urandom);
    chk("abort_next_gnt", 32'(gnt), 32'b0010);
    advance();
    cycle(4'b0000, 4'b0000, 1'b0, $urandom);
    $display("seq abort: abort_cnt=%0d", abort_cnt);

    // Random traffic against the model.
    rq = '0;
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] l;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) rq[b] = $urandom_range(0, 1) == 1;
        l[b] = $urandom_range(0, 3) == 0;
      end
      cycle(rq, l, $urandom_range(0, 4) == 0, $urandom);
    end
    $display("seq random: 3000 cycles done");

    // Drive abort_cnt into saturation.
    for (int k = 0; k < 300; k++) begin
      cycle(4'b0001, 4'b0000, 1'b0, $urandom);
      cycle(4'b0000, 4'b0000, 1'b0, $urandom);
    end
    drive_check(4'b0000, 4'b0000, 1'b0, $urandom);
    chk("abort_saturate", 32'(abort_cnt), 32'd255);
    advance();
    $display("seq saturate: abort_cnt=%0d", abort_cnt);

    // Asynchronous reset in the middle of a burst.
    cycle(4'b1111, 4'b0000, 1'b0, $urandom);
    cycle(4'b1111, 4'b0000, 1'b0, $urandom);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'd0);
    chk("async_rst_wr", 32'(fifo_wr), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_abort", 32'(abort_cnt), 32'd0);
    req = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(4'b1111, 4'b0000, 1'b0, $urandom);
    drive_check(4'b1111, 4'b0001, 1'b0, $urandom);
    chk("post_rst_winner", 32'(gnt), 32'b0001);
    advance();
    $display("seq async_reset: winner=%b", obs_gnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
